// File: rtl/store_narrow_unit.sv
// store_narrow_unit
//
// Write-path narrowing for data-memory/peripheral stores. A store from the
// MEM stage is checked for alignment, converted into a word address,
// lane-replicated write data and a byte-enable mask, and queued in a
// two-entry FIFO. The FIFO head is presented on a req/ack bus. Misaligned
// or reserved-opcode stores are dropped and reported with a one-cycle
// AdES pulse plus the faulting address.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   st_valid/st_ready store handshake from MEM (st_ready = !full)
//   st_op             00 word, 01 half, 10 byte, 11 reserved (error)
//   st_addr, st_data  store byte address and register value
//   bus_req/bus_ack   head-entry handshake toward DM / bridge
//   bus_addr          word address of the head entry
//   bus_wdata, bus_be lane-replicated data and byte enables of the head
//   exc_ades          one-cycle pulse for each rejected store
//   bad_vaddr         address of the most recent rejected store
//   idle              FIFO empty

module store_narrow_unit #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [1:0]  st_op,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  output logic        exc_ades,
  output logic [31:0] bad_vaddr,
  output logic        idle
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   addr_q  [DEPTH];
  logic [31:0]   wdata_q [DEPTH];
  logic [3:0]    be_q    [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic        full;
  logic        empty;
  logic        accept;
  logic        push;
  logic        pop;
  logic        aligned;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_be;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign st_ready = !full;
  assign idle     = empty;
  assign bus_req  = !empty;

  assign accept = st_valid && st_ready;
  assign push   = accept && aligned;
  assign pop    = bus_req && bus_ack;

  // Head entry drives the bus directly; it only changes on a pop (or a
  // push into an empty FIFO), so it holds while the bus stalls.
  assign bus_addr  = addr_q[rd_ptr];
  assign bus_wdata = wdata_q[rd_ptr];
  assign bus_be    = be_q[rd_ptr];

  // Alignment check and lane replication. Replicating the low bytes across
  // the word lets the byte enables alone select the target lane.
  always_comb begin
    aligned    = 1'b0;
    lane_wdata = st_data;
    lane_be    = 4'b0000;
    case (st_op)
      2'b00: begin
        aligned    = (st_addr[1:0] == 2'b00);
        lane_wdata = st_data;
        lane_be    = 4'b1111;
      end
      2'b01: begin
        aligned    = !st_addr[0];
        lane_wdata = {2{st_data[15:0]}};
        lane_be    = st_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        aligned    = 1'b1;
        lane_wdata = {4{st_data[7:0]}};
        lane_be    = 4'b0001 << st_addr[1:0];
      end
      default: begin
        aligned = 1'b0;
      end
    endcase
  end

  // FIFO storage and pointers. Storage is cleared on reset so the bus
  // outputs read as zero until the first accepted store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i]  <= '0;
        wdata_q[i] <= '0;
        be_q[i]    <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        addr_q[wr_ptr]  <= {st_addr[31:2], 2'b00};
        wdata_q[wr_ptr] <= lane_wdata;
        be_q[wr_ptr]    <= lane_be;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Rejected stores: pulse for exactly the cycle after acceptance and
  // capture the faulting byte address on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exc_ades  <= 1'b0;
      bad_vaddr <= '0;
    end else begin
      exc_ades <= accept && !aligned;
      if (accept && !aligned) begin
        bad_vaddr <= st_addr;
      end
    end
  end

endmodule

// File: tb/tb_store_narrow_unit.sv
// tb_store_narrow_unit
//
// Directed bench for store_narrow_unit: a table of single-store vectors
// (lane encoding and rejection) plus hand-written sequences for
// backpressure, simultaneous push/pop, back-to-back errors and reset
// in the middle of operation.

module tb_store_narrow_unit;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [1:0]  st_op;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic        exc_ades;
  logic [31:0] bad_vaddr;
  logic        idle;

  int compared;
  int mismatched;

  store_narrow_unit #(.DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_op     (st_op),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .bus_req   (bus_req),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_be    (bus_be),
    .bus_ack   (bus_ack),
    .exc_ades  (exc_ades),
    .bad_vaddr (bad_vaddr),
    .idle      (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_be;
  } vec_t;

  vec_t vecs [10];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [1:0] op,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic ack);
    st_valid = valid;
    st_op    = op;
    st_addr  = addr;
    st_data  = data;
    bus_ack  = ack;
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    #3 rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b1;
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);

    vecs[0] = '{2'b10, 32'h0000_1003, 32'h1234_56AB, 1'b0, 32'h0000_1000, 32'hABAB_ABAB, 4'b1000};
    vecs[1] = '{2'b01, 32'h0000_1002, 32'hDEAD_BEEF, 1'b0, 32'h0000_1000, 32'hBEEF_BEEF, 4'b1100};
    vecs[2] = '{2'b01, 32'h0000_1000, 32'h0000_CAFE, 1'b0, 32'h0000_1000, 32'hCAFE_CAFE, 4'b0011};
    vecs[3] = '{2'b00, 32'h0000_2004, 32'h89AB_CDEF, 1'b0, 32'h0000_2004, 32'h89AB_CDEF, 4'b1111};
    vecs[4] = '{2'b10, 32'h0000_3000, 32'h0000_0055, 1'b0, 32'h0000_3000, 32'h5555_5555, 4'b0001};
    vecs[5] = '{2'b10, 32'h0000_3001, 32'hFFFF_FF66, 1'b0, 32'h0000_3000, 32'h6666_6666, 4'b0010};
    vecs[6] = '{2'b10, 32'hF000_3002, 32'h0000_0077, 1'b0, 32'hF000_3000, 32'h7777_7777, 4'b0100};
    vecs[7] = '{2'b00, 32'h0000_2002, 32'h1111_1111, 1'b1, 32'h0, 32'h0, 4'b0000};
    vecs[8] = '{2'b01, 32'h0000_2001, 32'h2222_2222, 1'b1, 32'h0, 32'h0, 4'b0000};
    vecs[9] = '{2'b11, 32'h0000_0040, 32'h3333_3333, 1'b1, 32'h0, 32'h0, 4'b0000};

    // Reset state, asserted mid-cycle and checked before any edge.
    #3 rst_n = 1'b0;
    #1;
    checkOutput("rst_bus_req",   32'(bus_req),   32'd0);
    checkOutput("rst_bus_addr",  bus_addr,       32'h0);
    checkOutput("rst_bus_wdata", bus_wdata,      32'h0);
    checkOutput("rst_bus_be",    32'(bus_be),    32'h0);
    checkOutput("rst_exc_ades",  32'(exc_ades),  32'd0);
    checkOutput("rst_bad_vaddr", bad_vaddr,      32'h0);
    checkOutput("rst_idle",      32'(idle),      32'd1);
    checkOutput("rst_st_ready",  32'(st_ready),  32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // Table-driven single stores with the bus acking every cycle.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, vecs[i].op, vecs[i].addr, vecs[i].data, 1'b1);
      tick();
      applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
      checkOutput($sformatf("v%0d_exc_ades", i), 32'(exc_ades), 32'(vecs[i].err));
      checkOutput($sformatf("v%0d_bus_req", i), 32'(bus_req), 32'(!vecs[i].err));
      if (vecs[i].err) begin
        checkOutput($sformatf("v%0d_bad_vaddr", i), bad_vaddr, vecs[i].addr);
      end else begin
        checkOutput($sformatf("v%0d_bus_addr", i),  bus_addr,     vecs[i].exp_addr);
        checkOutput($sformatf("v%0d_bus_wdata", i), bus_wdata,    vecs[i].exp_wdata);
        checkOutput($sformatf("v%0d_bus_be", i),    32'(bus_be),  32'(vecs[i].exp_be));
      end
      tick();
      checkOutput($sformatf("v%0d_idle_after", i), 32'(idle), 32'd1);
      checkOutput($sformatf("v%0d_exc_clear", i), 32'(exc_ades), 32'd0);
    end

    // Backpressure: fill the FIFO, hold a third store, then drain in order.
    doReset();
    applyStimulus(1'b1, 2'b00, 32'h0000_0000, 32'hA000_0000, 1'b0);
    tick();
    checkOutput("bp1_ready", 32'(st_ready), 32'd1);
    checkOutput("bp1_addr",  bus_addr,      32'h0);
    applyStimulus(1'b1, 2'b00, 32'h0000_0004, 32'hA000_0004, 1'b0);
    tick();
    checkOutput("bp2_ready", 32'(st_ready), 32'd0);
    checkOutput("bp2_addr",  bus_addr,      32'h0);
    checkOutput("bp2_wdata", bus_wdata,     32'hA000_0000);
    applyStimulus(1'b1, 2'b00, 32'h0000_0008, 32'hA000_0008, 1'b0);
    tick();
    checkOutput("bp3_ready", 32'(st_ready), 32'd0);
    checkOutput("bp3_addr",  bus_addr,      32'h0);
    checkOutput("bp3_req",   32'(bus_req),  32'd1);
    applyStimulus(1'b1, 2'b00, 32'h0000_0008, 32'hA000_0008, 1'b1);
    tick();
    checkOutput("dr1_addr",  bus_addr,      32'h4);
    checkOutput("dr1_ready", 32'(st_ready), 32'd1);
    tick();
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    checkOutput("dr2_addr",  bus_addr,      32'h8);
    checkOutput("dr2_wdata", bus_wdata,     32'hA000_0008);
    checkOutput("dr2_req",   32'(bus_req),  32'd1);
    tick();
    checkOutput("dr3_idle",  32'(idle),     32'd1);
    checkOutput("dr3_req",   32'(bus_req),  32'd0);

    // Simultaneous push and pop with one entry queued.
    applyStimulus(1'b1, 2'b00, 32'h0000_0020, 32'h2020_2020, 1'b0);
    tick();
    checkOutput("pp0_addr", bus_addr, 32'h20);
    applyStimulus(1'b1, 2'b00, 32'h0000_0010, 32'h1010_1010, 1'b1);
    tick();
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    checkOutput("pp1_addr",  bus_addr,      32'h10);
    checkOutput("pp1_wdata", bus_wdata,     32'h1010_1010);
    checkOutput("pp1_ready", 32'(st_ready), 32'd1);
    checkOutput("pp1_req",   32'(bus_req),  32'd1);
    tick();
    checkOutput("pp2_addr",  bus_addr,      32'h10);
    bus_ack = 1'b1;
    tick();
    checkOutput("pp3_idle",  32'(idle),     32'd1);

    // Back-to-back rejected stores.
    applyStimulus(1'b1, 2'b00, 32'h0000_2002, 32'h0, 1'b1);
    tick();
    checkOutput("me1_exc", 32'(exc_ades), 32'd1);
    checkOutput("me1_bad", bad_vaddr,     32'h0000_2002);
    applyStimulus(1'b1, 2'b01, 32'h0000_2001, 32'h0, 1'b1);
    tick();
    checkOutput("me2_exc", 32'(exc_ades), 32'd1);
    checkOutput("me2_bad", bad_vaddr,     32'h0000_2001);
    checkOutput("me2_req", 32'(bus_req),  32'd0);
    applyStimulus(1'b1, 2'b11, 32'h0000_0040, 32'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    checkOutput("me3_exc", 32'(exc_ades), 32'd1);
    checkOutput("me3_bad", bad_vaddr,     32'h0000_0040);
    checkOutput("me3_req", 32'(bus_req),  32'd0);
    tick();
    checkOutput("me4_exc", 32'(exc_ades), 32'd0);
    checkOutput("me4_bad", bad_vaddr,     32'h0000_0040);
    checkOutput("me4_req", 32'(bus_req),  32'd0);

    // Reset with two entries queued and the bus stalled.
    applyStimulus(1'b1, 2'b00, 32'h0000_0100, 32'h0000_0100, 1'b0);
    tick();
    applyStimulus(1'b1, 2'b10, 32'h0000_0105, 32'h0000_00C3, 1'b0);
    tick();
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    checkOutput("rm0_req",   32'(bus_req),  32'd1);
    checkOutput("rm0_ready", 32'(st_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rm1_req",   32'(bus_req),  32'd0);
    checkOutput("rm1_addr",  bus_addr,      32'h0);
    checkOutput("rm1_idle",  32'(idle),     32'd1);
    checkOutput("rm1_ready", 32'(st_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checkOutput($sformatf("rm2_req_c%0d", c), 32'(bus_req), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
